// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: 512 Hz frame divider, 8-step tick decode, trigger/active tracking, master enable.
// Optional: define APU_NR52_READBACK_EN to add the combinational nr52_rdata readback port.
module apu_frame_sequencer #(
  parameter int FRAME_DIV = 32768,
  parameter int DIV_W     = 16
) (
  input  logic       system_clock,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [2:0] wr_sel,
  input  logic [7:0] wr_data,
  input  logic [3:0] len_expired,
  input  logic [3:0] dac_on,
  output logic       tick_length,
  output logic       tick_sweep,
  output logic       tick_envelope,
  output logic [3:0] trigger,
  output logic [3:0] ch_active,
  output logic       master_en,
  output logic [2:0] frame_step
`ifdef APU_NR52_READBACK_EN
  ,
  output logic [7:0] nr52_rdata
`endif
);

  localparam logic [DIV_W-1:0] DivLast = DIV_W'(FRAME_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       step_q, step_d;
  logic             master_q, master_d;
  logic             tickLen_q, tickLen_d;
  logic             tickSweep_q, tickSweep_d;
  logic             tickEnv_q, tickEnv_d;
  logic [3:0]       trig_q, trig_d;
  logic [3:0]       active_q, active_d;

  logic             nr52Wr;
  logic             enableReq;
  logic             disableReq;
  logic             stepEdge;
  logic [3:0]       trigReq;

  always_comb begin
    nr52Wr     = wr_en && (wr_sel == 3'd4);
    enableReq  = nr52Wr && wr_data[7] && !master_q;
    disableReq = nr52Wr && !wr_data[7] && master_q;
    stepEdge   = master_q && (div_q == DivLast);
    trigReq    = 4'b0000;
    if (wr_en && (wr_sel < 3'd4) && wr_data[7] && master_q) begin
      trigReq = 4'b0001 << wr_sel[1:0];
    end
  end

  always_comb begin
    master_d    = master_q;
    div_d       = div_q;
    step_d      = step_q;
    tickLen_d   = 1'b0;
    tickSweep_d = 1'b0;
    tickEnv_d   = 1'b0;
    trig_d      = trigReq;
    active_d    = active_q;

    if (master_q) begin
      if (stepEdge) begin
        div_d       = '0;
        step_d      = step_q + 3'd1;
        // Ticks carry the decode of the step being left, not the one entered.
        tickLen_d   = !step_q[0];
        tickSweep_d = (step_q[1:0] == 2'b10);
        tickEnv_d   = (step_q == 3'd7);
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end

    // Trigger overrides length expiry; a disabled DAC overrides everything.
    for (int i = 0; i < 4; i++) begin
      if (len_expired[i]) active_d[i] = 1'b0;
      if (trigReq[i])     active_d[i] = dac_on[i];
      if (!dac_on[i])     active_d[i] = 1'b0;
    end

    if (enableReq) begin
      master_d = 1'b1;
      div_d    = '0;
      step_d   = '0;
    end

    if (disableReq) begin
      master_d    = 1'b0;
      div_d       = '0;
      step_d      = '0;
      tickLen_d   = 1'b0;
      tickSweep_d = 1'b0;
      tickEnv_d   = 1'b0;
      trig_d      = 4'b0000;
      active_d    = 4'b0000;
    end
  end

  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) begin
      div_q       <= '0;
      step_q      <= '0;
      master_q    <= 1'b0;
      tickLen_q   <= 1'b0;
      tickSweep_q <= 1'b0;
      tickEnv_q   <= 1'b0;
      trig_q      <= 4'b0000;
      active_q    <= 4'b0000;
    end else begin
      div_q       <= div_d;
      step_q      <= step_d;
      master_q    <= master_d;
      tickLen_q   <= tickLen_d;
      tickSweep_q <= tickSweep_d;
      tickEnv_q   <= tickEnv_d;
      trig_q      <= trig_d;
      active_q    <= active_d;
    end
  end

  assign tick_length   = tickLen_q;
  assign tick_sweep    = tickSweep_q;
  assign tick_envelope = tickEnv_q;
  assign trigger       = trig_q;
  assign ch_active     = active_q;
  assign master_en     = master_q;
  assign frame_step    = step_q;

`ifdef APU_NR52_READBACK_EN
  assign nr52_rdata = {master_q, 3'b111, active_q};
`endif

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Directed self-checking bench for apu_frame_sequencer, run with a short frame divider.
module tb_apu_frame_sequencer;

  localparam int FRAME_DIV = 8;
  localparam int DIV_W     = 4;

  logic       system_clock = 1'b0;
  logic       reset        = 1'b0;
  logic       wr_en        = 1'b0;
  logic [2:0] wr_sel       = 3'd0;
  logic [7:0] wr_data      = 8'h00;
  logic [3:0] len_expired  = 4'b0000;
  logic [3:0] dac_on       = 4'b0000;
  logic       tick_length;
  logic       tick_sweep;
  logic       tick_envelope;
  logic [3:0] trigger;
  logic [3:0] ch_active;
  logic       master_en;
  logic [2:0] frame_step;
`ifdef APU_NR52_READBACK_EN
  logic [7:0] nr52_rdata;
`endif

  int checkCount = 0;
  int errorCount = 0;

  apu_frame_sequencer #(.FRAME_DIV(FRAME_DIV), .DIV_W(DIV_W)) dut (
    .system_clock (system_clock),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_sel       (wr_sel),
    .wr_data      (wr_data),
    .len_expired  (len_expired),
    .dac_on       (dac_on),
    .tick_length  (tick_length),
    .tick_sweep   (tick_sweep),
    .tick_envelope(tick_envelope),
    .trigger      (trigger),
    .ch_active    (ch_active),
    .master_en    (master_en),
    .frame_step   (frame_step)
`ifdef APU_NR52_READBACK_EN
    ,
    .nr52_rdata   (nr52_rdata)
`endif
  );

  always #5 system_clock = ~system_clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge system_clock);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [2:0] sel, input logic [7:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_data = data;
    @(posedge system_clock);
    #1;
    wr_en   = 1'b0;
    wr_sel  = 3'd0;
    wr_data = 8'h00;
  endtask

  task automatic waitStep(input logic [2:0] target, output bit found);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (frame_step == target) found = 1'b1;
      else stepCycles(1);
    end
  endtask

  initial begin
    int nLen, nSweep, nEnv, firstLen, firstSweep, envAt, wide, quietTicks, quietTrig, stepMoved;
    bit found;
    logic prevAny;

    // Reset state
    stepCycles(3);
    checkOutput("reset_outputs",
                {tick_length, tick_sweep, tick_envelope, trigger, ch_active, master_en, frame_step},
                32'd0);
    reset = 1'b1;
    stepCycles(2);
    checkOutput("idle_master", master_en, 1'b0);
    checkOutput("idle_step", frame_step, 3'd0);
    checkOutput("idle_ticks", {tick_length, tick_sweep, tick_envelope}, 3'b000);

    // Enable and count a full 8-step sequence
    applyStimulus(3'd4, 8'h80);
    checkOutput("enable_master", master_en, 1'b1);
    checkOutput("enable_step", frame_step, 3'd0);
    nLen = 0; nSweep = 0; nEnv = 0; firstLen = 0; firstSweep = 0; envAt = 0; wide = 0;
    prevAny = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      stepCycles(1);
      if (tick_length) begin
        nLen++;
        if (firstLen == 0) firstLen = i;
      end
      if (tick_sweep) begin
        nSweep++;
        if (firstSweep == 0) firstSweep = i;
      end
      if (tick_envelope) begin
        nEnv++;
        envAt = i;
      end
      if (prevAny && (tick_length || tick_sweep || tick_envelope)) wide++;
      prevAny = tick_length || tick_sweep || tick_envelope;
    end
    checkOutput("first_len_cycle", firstLen, 8);
    checkOutput("len_count", nLen, 4);
    checkOutput("sweep_count", nSweep, 2);
    checkOutput("first_sweep_cycle", firstSweep, 24);
    checkOutput("env_count", nEnv, 1);
    checkOutput("env_cycle", envAt, 64);
    checkOutput("tick_width", wide, 0);
    checkOutput("step_wrap", frame_step, 3'd0);

    // Triggers on all four channels; channels 2 and 4 have no DAC
    dac_on = 4'b0101;
    for (int x = 0; x < 4; x++) begin
      applyStimulus(3'(x), 8'h80);
      checkOutput($sformatf("trig_ch%0d", x + 1), trigger, 4'b0001 << x);
    end
    stepCycles(1);
    checkOutput("trig_clear", trigger, 4'b0000);
    checkOutput("active_after_trig", ch_active, 4'b0101);
    applyStimulus(3'd1, 8'h7F);
    checkOutput("trig_bit7_low", trigger, 4'b0000);
    checkOutput("active_bit7_low", ch_active, 4'b0101);
    applyStimulus(3'd5, 8'hFF);
    checkOutput("sel5_ignored", {trigger, master_en}, 5'b0000_1);
    dac_on = 4'b0001;
    stepCycles(1);
    checkOutput("dac_off_clears", ch_active, 4'b0001);

    // Trigger and length expiry together, then expiry alone
    len_expired = 4'b0001;
    applyStimulus(3'd0, 8'h80);
    len_expired = 4'b0000;
    checkOutput("trig_vs_len_trig", trigger, 4'b0001);
    checkOutput("trig_vs_len_active", ch_active, 4'b0001);
    stepCycles(1);
    len_expired = 4'b0001;
    stepCycles(1);
    len_expired = 4'b0000;
    checkOutput("len_expired_clears", ch_active, 4'b0000);
    applyStimulus(3'd0, 8'h80);
    checkOutput("retrigger_active", ch_active, 4'b0001);

    // Disable mid-frame at step 5
    waitStep(3'd5, found);
    checkOutput("reach_step5", found, 1'b1);
    applyStimulus(3'd4, 8'h00);
    checkOutput("disable_master", master_en, 1'b0);
    checkOutput("disable_active", ch_active, 4'b0000);
    checkOutput("disable_step", frame_step, 3'd0);
    checkOutput("disable_ticks", {tick_length, tick_sweep, tick_envelope, trigger}, 7'd0);
    quietTicks = 0; quietTrig = 0; stepMoved = 0;
    for (int i = 1; i <= 100; i++) begin
      if (i == 50) applyStimulus(3'd0, 8'h80);
      else stepCycles(1);
      if (tick_length || tick_sweep || tick_envelope) quietTicks++;
      if (trigger != 4'b0000) quietTrig++;
      if (frame_step != 3'd0) stepMoved++;
    end
    checkOutput("quiet_ticks", quietTicks, 0);
    checkOutput("quiet_trigger", quietTrig, 0);
    checkOutput("quiet_step", stepMoved, 0);

    // Re-enable; rewriting the same value must not restart the divider
    applyStimulus(3'd4, 8'h80);
    firstLen = 0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 4) applyStimulus(3'd4, 8'h80);
      else stepCycles(1);
      if (tick_length && firstLen == 0) firstLen = i;
    end
    checkOutput("reenable_first_len", firstLen, 8);
    checkOutput("reenable_step", frame_step, 3'd1);

    dac_on = 4'b1010;
    applyStimulus(3'd1, 8'h80);
    applyStimulus(3'd3, 8'h80);
    checkOutput("active_1010", ch_active, 4'b1010);
`ifdef APU_NR52_READBACK_EN
    checkOutput("nr52_rdata", nr52_rdata, 8'hFA);
`endif

    // Asynchronous reset mid-count
    waitStep(3'd3, found);
    checkOutput("reach_step3", found, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_reset_outputs",
                {tick_length, tick_sweep, tick_envelope, trigger, ch_active, master_en, frame_step},
                32'd0);
    #1;
    reset = 1'b1;
    stepCycles(3);
    checkOutput("post_reset_master", master_en, 1'b0);
    checkOutput("post_reset_step", frame_step, 3'd0);
    checkOutput("post_reset_active", ch_active, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
